ddr_local_responder: RTL and testbench



---
 rtl/ddr_local_pkg.sv | 20 ++
 rtl/ddr_local_ram.sv | 31 +++
 rtl/ddr_local_responder.sv | 170 +++++++++++++++++
 tb/tb_ddr_local_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ddr_local_pkg.sv
// rtl/ddr_local_pkg.sv - shared state encodings and defaults for the DDR local-interface responder
package ddr_local_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WR_BURST = 3'd2,
        ST_RD_LAT   = 3'd3,
        ST_RD_DATA  = 3'd4
    } state_t;

    localparam int DEFAULT_READ_LATENCY = 4;
    localparam int DEFAULT_INIT_CYCLES  = 16;

    // A zero burst length is a one-word burst.
    function automatic logic [6:0] eff_size(input logic [6:0] size);
        return (size == 7'd0) ? 7'd1 : size;
    endfunction

endpackage

// File: rtl/ddr_local_ram.sv
// rtl/ddr_local_ram.sv - single-port byte-enabled backing store with one-cycle registered read
module ddr_local_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Contents are deliberately not reset so data survives a re-initialisation.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)               rdata <= 32'd0;
        else if (en && !we)    rdata <= mem[addr];
    end

endmodule

// File: rtl/ddr_local_responder.sv
// rtl/ddr_local_responder.sv - DDR-controller local-side responder: init delay, write bursts, latency-timed read bursts
module ddr_local_responder
    import ddr_local_pkg::*;
#(
    parameter int ADDR_WIDTH     = 23,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int READ_LATENCY   = DEFAULT_READ_LATENCY,
    parameter int INIT_CYCLES    = DEFAULT_INIT_CYCLES
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [ADDR_WIDTH-1:0] local_address_i,
    input  logic                  local_write_req_i,
    input  logic                  local_read_req_i,
    input  logic                  local_burstbegin_i,
    input  logic [31:0]           local_wdata_i,
    input  logic [3:0]            local_be_i,
    input  logic [6:0]            local_size_i,
    output logic [31:0]           local_rdata_o,
    output logic                  local_rdata_valid_o,
    output logic                  local_ready_o,
    output logic                  local_init_done_o,
    output logic                  protocol_err_o
);

    localparam int MW     = MEM_WORDS_LOG2;
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    state_t              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [3:0]          lat_cnt_q, lat_cnt_d;
    logic [MW-1:0]       wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [6:0]          wr_rem_q, wr_rem_d, rd_rem_q, rd_rem_d;
    logic                ready_q, ready_d;
    logic                init_done_q, valid_q, err_q;

    logic                ram_en, ram_we, err_set, start_wr, any_req;
    logic [MW-1:0]       ram_addr;
    logic [6:0]          sz;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^local_address_i[ADDR_WIDTH-1:MW];
    assign any_req          = local_write_req_i | local_read_req_i;
    assign sz               = eff_size(local_size_i);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_rem_d   = wr_rem_q;
        rd_addr_d  = rd_addr_q;
        rd_rem_d   = rd_rem_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = rd_addr_q;
        err_set    = 1'b0;
        start_wr   = 1'b0;

        case (state_q)
            ST_INIT: begin
                err_set = any_req;
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) state_d = ST_IDLE;
                else                                        init_cnt_d = init_cnt_q + 1'b1;
            end
            ST_IDLE: begin
                if (!ready_q) begin
                    err_set = any_req;
                end else if (local_write_req_i && local_burstbegin_i) begin
                    start_wr = 1'b1;
                    err_set  = local_read_req_i;
                end else if (local_read_req_i && local_burstbegin_i) begin
                    rd_addr_d = local_address_i[MW-1:0];
                    rd_rem_d  = sz;
                    lat_cnt_d = 4'd0;
                    state_d   = (READ_LATENCY <= 2) ? ST_RD_DATA : ST_RD_LAT;
                end else begin
                    err_set = any_req;
                end
            end
            ST_WR_BURST: begin
                if (local_write_req_i && local_burstbegin_i) begin
                    err_set  = 1'b1;
                    start_wr = 1'b1;
                end else begin
                    err_set = local_read_req_i;
                    if (local_write_req_i) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = wr_addr_q;
                        wr_addr_d = wr_addr_q + MW'(1);
                        wr_rem_d  = wr_rem_q - 7'd1;
                        if (wr_rem_q == 7'd1) state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_LAT: begin
                err_set = any_req;
                if (lat_cnt_q == 4'(READ_LATENCY - 3)) state_d = ST_RD_DATA;
                else                                    lat_cnt_d = lat_cnt_q + 4'd1;
            end
            ST_RD_DATA: begin
                // Word issued here appears on rdata with valid one edge later.
                err_set   = any_req;
                ram_en    = 1'b1;
                rd_addr_d = rd_addr_q + MW'(1);
                rd_rem_d  = rd_rem_q - 7'd1;
                if (rd_rem_q == 7'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase

        if (start_wr) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = local_address_i[MW-1:0];
            wr_addr_d = local_address_i[MW-1:0] + MW'(1);
            wr_rem_d  = sz - 7'd1;
            state_d   = (sz == 7'd1) ? ST_IDLE : ST_WR_BURST;
        end

        // Hold ready low through the final read-data cycle so it returns just after it.
        ready_d = ((state_d == ST_IDLE) || (state_d == ST_WR_BURST)) && (state_q != ST_RD_DATA);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            wr_addr_q   <= '0;
            wr_rem_q    <= '0;
            rd_addr_q   <= '0;
            rd_rem_q    <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_rem_q    <= wr_rem_d;
            rd_addr_q   <= rd_addr_d;
            rd_rem_q    <= rd_rem_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_q | ((state_q == ST_INIT) && (state_d == ST_IDLE));
            valid_q     <= (state_q == ST_RD_DATA);
            err_q       <= err_q | err_set;
        end
    end

    ddr_local_ram #(.AW(MW)) u_ram (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .en    (ram_en & ~wb_rst_i),
        .we    (ram_we),
        .be    (local_be_i),
        .addr  (ram_addr),
        .wdata (local_wdata_i),
        .rdata (local_rdata_o)
    );

    assign local_rdata_valid_o = valid_q;
    assign local_ready_o       = ready_q;
    assign local_init_done_o   = init_done_q;
    assign protocol_err_o      = err_q;

endmodule

// File: tb/tb_ddr_local_responder.sv
// tb/tb_ddr_local_responder.sv - directed-vector bench for ddr_local_responder
module tb_ddr_local_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] address;
    logic        write_req, read_req, burstbegin;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [6:0]  size;
    logic [31:0] rdata;
    logic        rdata_valid, ready, init_done, perr;

    int vectors    = 0;
    int miscompares = 0;
    logic [31:0] exp_data [0:7];

    always #5 clk = ~clk;

    ddr_local_responder dut (
        .wb_clk_i            (clk),
        .wb_rst_i            (rst),
        .local_address_i     (address),
        .local_write_req_i   (write_req),
        .local_read_req_i    (read_req),
        .local_burstbegin_i  (burstbegin),
        .local_wdata_i       (wdata),
        .local_be_i          (be),
        .local_size_i        (size),
        .local_rdata_o       (rdata),
        .local_rdata_valid_o (rdata_valid),
        .local_ready_o       (ready),
        .local_init_done_o   (init_done),
        .protocol_err_o      (perr)
    );

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [22:0] a, input logic [31:0] d, input logic [3:0] b,
                      input logic bb, input logic [6:0] sz);
        address = a; wdata = d; be = b; burstbegin = bb; size = sz; write_req = 1'b1;
        @(negedge clk);
        write_req = 1'b0; burstbegin = 1'b0;
    endtask

    task automatic expect_init(input string tag);
        int n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ready) begin n = i; break; end
        end
        check_vec({tag, "_ready_latency"}, n, 16);
        check_vec({tag, "_init_done"}, init_done, 1'b1);
    endtask

    task automatic read_burst(input string tag, input logic [22:0] a, input logic [6:0] sz, input int nexp);
        int first_v = -1, last_v = -1, nv = 0, rdy_at = -1;
        address = a; size = sz; read_req = 1'b1; burstbegin = 1'b1;
        for (int i = 1; i <= 4 + nexp + 3; i++) begin
            @(negedge clk);
            if (i == 1) begin read_req = 1'b0; burstbegin = 1'b0; end
            if (rdata_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                if (nv < 8) check_vec($sformatf("%s_data%0d", tag, nv), rdata, exp_data[nv]);
                nv++;
            end
            if (rdy_at < 0 && ready) rdy_at = i;
        end
        check_vec({tag, "_first_valid"}, first_v, 4);
        check_vec({tag, "_valid_count"}, nv, nexp);
        check_vec({tag, "_no_gaps"}, last_v - first_v + 1, nexp);
        check_vec({tag, "_ready_back"}, rdy_at, 4 + nexp);
    endtask

    initial begin
        int nv;
        rst = 1'b1; address = '0; write_req = 1'b0; read_req = 1'b0; burstbegin = 1'b0;
        wdata = '0; be = '0; size = '0;
        @(negedge clk); @(negedge clk);
        check_vec("rst_ready", ready, 1'b0);
        check_vec("rst_init_done", init_done, 1'b0);
        check_vec("rst_valid", rdata_valid, 1'b0);
        check_vec("rst_err", perr, 1'b0);
        check_vec("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        expect_init("init1");

        // Byte-enabled overwrite of a single word
        wr(23'h10, 32'hDEADBEEF, 4'hF, 1'b1, 7'd1);
        wr(23'h10, 32'h000000AA, 4'h1, 1'b1, 7'd1);
        exp_data[0] = 32'hDEADBEAA;
        read_burst("be_merge", 23'h10, 7'd1, 1);

        // Burst with stall, wrapping past the top of the store
        wr(23'h3FE, 32'd1, 4'hF, 1'b1, 7'd4);
        wr(23'h0, 32'd2, 4'hF, 1'b0, 7'd0);
        wr(23'h0, 32'd3, 4'hF, 1'b0, 7'd0);
        repeat (2) @(negedge clk);
        wr(23'h0, 32'd4, 4'hF, 1'b0, 7'd0);
        exp_data[0] = 32'd1; exp_data[1] = 32'd2; exp_data[2] = 32'd3; exp_data[3] = 32'd4;
        read_burst("wrap", 23'h3FE, 7'd4, 4);
        exp_data[0] = 32'd3; exp_data[1] = 32'd4;
        read_burst("upper_bits", 23'h1000, 7'd2, 2);

        // Eight-beat burst
        for (int i = 0; i < 8; i++) begin
            wr(23'h20 + 23'(i), 32'h100 + 32'(i), 4'hF, (i == 0), 7'd8);
            exp_data[i] = 32'h100 + 32'(i);
        end
        read_burst("rd8", 23'h20, 7'd8, 8);

        // Size zero behaves as one word
        wr(23'h70, 32'h5A5A5A5A, 4'hF, 1'b1, 7'd0);
        wr(23'h71, 32'h12345678, 4'hF, 1'b1, 7'd1);
        exp_data[0] = 32'h5A5A5A5A;
        read_burst("size0", 23'h70, 7'd0, 1);
        check_vec("err_clean", perr, 1'b0);

        // Read and write together: write wins
        address = 23'h40; wdata = 32'h77; be = 4'hF; size = 7'd1;
        write_req = 1'b1; read_req = 1'b1; burstbegin = 1'b1;
        @(negedge clk);
        write_req = 1'b0; read_req = 1'b0; burstbegin = 1'b0;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdata_valid) nv++;
        end
        check_vec("dual_no_valid", nv, 0);
        check_vec("dual_err", perr, 1'b1);
        exp_data[0] = 32'h77;
        read_burst("dual_wr", 23'h40, 7'd1, 1);
        check_vec("dual_err_sticky", perr, 1'b1);

        // Reset during the third beat of an eight-beat read
        address = 23'h20; size = 7'd8; read_req = 1'b1; burstbegin = 1'b1;
        nv = 0;
        for (int i = 0; i < 20 && nv < 3; i++) begin
            @(negedge clk);
            read_req = 1'b0; burstbegin = 1'b0;
            if (rdata_valid) nv++;
        end
        check_vec("mid_beats_seen", nv, 3);
        rst = 1'b1;
        @(negedge clk);
        check_vec("mid_valid_low", rdata_valid, 1'b0);
        check_vec("mid_ready_low", ready, 1'b0);
        check_vec("mid_init_done_low", init_done, 1'b0);
        check_vec("mid_err_clear", perr, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        expect_init("init2");
        for (int i = 0; i < 8; i++) exp_data[i] = 32'h100 + 32'(i);
        read_burst("retained", 23'h20, 7'd8, 8);

        // New burstbegin abandons a write burst in progress
        wr(23'h50, 32'hA0, 4'hF, 1'b1, 7'd4);
        wr(23'h0, 32'hA1, 4'hF, 1'b0, 7'd0);
        wr(23'h60, 32'hB0, 4'hF, 1'b1, 7'd2);
        wr(23'h0, 32'hB1, 4'hF, 1'b0, 7'd0);
        check_vec("abandon_err", perr, 1'b1);
        exp_data[0] = 32'hB0; exp_data[1] = 32'hB1;
        read_burst("new_burst", 23'h60, 7'd2, 2);
        exp_data[0] = 32'hA0; exp_data[1] = 32'hA1;
        read_burst("old_burst", 23'h50, 7'd2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
